bash_sponge_ctrl: RTL and testbench
===================================

// Module: bash_sponge_ctrl
// PURPOSE
//  Absorb/squeeze controller sitting directly upstream and downstream of the bash-f permutation core.
//  - Packs a 64-bit message-word stream into the rate part of the 1536-bit sponge state and pads it.
//  - Hands each full state to bash-f via start/done and captures the permuted state.
//  - After the final block, presents the 2L-bit digest (bash-hash_L per STB 34.101.77).
// PARAMETERS
//  L       128  security level; legal 128/192/256, any other value is an elaboration error
//  RATE_W  (1536-4*L)/SLEN  derived, not overridable: rate in 64-bit words (16/12/8)
//  HASH_W  2*L  derived: digest width in bits
// PORTS
//  clk       in   1       single clock, rising edge
//  rst_n     in   1       asynchronous, active-low reset
//  s_data    in   64      message word; byte k = bits [8k+7:8k] (little-endian)
//  s_nbytes  in   4       valid bytes in s_data (0..8); sampled only with s_last; non-last words are full
//  s_last    in   1       final word of the message
//  s_valid   in   1       word available
//  s_ready   out  1       word accepted when s_valid & s_ready
//  f_start   out  1       one-cycle pulse: f_state_o is valid, permutation begins
//  f_state_o out  1536    state to bash-f, word i = bits [64i+63:64i]
//  f_state_i in   1536    permuted state from bash-f
//  f_done    in   1       one-cycle pulse: f_state_i valid
//  h_data    out  HASH_W  digest = state words 0..HASH_W/64-1
//  h_valid   out  1       digest available
//  h_ready   in   1       digest consumed when h_valid & h_ready
// BEHAVIOUR
//  - Reset: FSM=INIT, all outputs 0, state regs 0, word counter 0, pad_pending 0.
//  - INIT (1 cycle): state <= 0, word 23 <= L/4 (64-bit), wcnt <= 0 -> ABSORB. s_ready=0.
//  - ABSORB: s_ready=1. Each accepted word is written to state[wcnt], then wcnt++.
//    - Non-last word, wcnt reaches RATE_W -> PERM.
//    - Last word, s_nbytes<8: bytes >= s_nbytes cleared, byte s_nbytes = 0x40.
//      Remaining rate words wcnt+1..RATE_W-1 zeroed in the same cycle -> PERM with final=1.
//    - Last word, s_nbytes==8: word stored whole, pad_pending=1.
//      If the block is now full -> PERM with final=0; otherwise -> PAD.
//    - s_nbytes==0 with s_last: the word is all padding (0x40 in byte 0).
//  - PAD (1 cycle): state[wcnt] = 64'h40, words above it up to RATE_W-1 = 0, pad_pending=0.
//    Sets final=1 -> PERM. Entered from PERM when pad_pending at block start, with wcnt=0.
//  - PERM: f_start pulses exactly once on entry; f_state_o = current state, held stable until f_done.
//    - On f_done: state <= f_state_i, wcnt <= 0.
//    - Next state: final -> SQUEEZE; pad_pending -> PAD; else -> ABSORB. s_ready=0 throughout.
//    - A message that exactly fills k blocks therefore costs k+1 permutations.
//  - SQUEEZE: h_valid=1, h_data stable. On h_ready -> INIT next message, h_valid deasserts next cycle.
//  - Capacity words RATE_W..23 are never written by absorb; they change only from f_state_i.
//  - f_done outside PERM is ignored. s_valid outside ABSORB is not accepted (no drops, no overrun).
//  - Reset mid-operation: immediate return to reset values; an in-flight f_done after reset is ignored.
//  - Throughput: 1 word/cycle in ABSORB. Latency last-word -> h_valid = perm latency + 2 cycles.
// STRUCTURE
//  - bash_hash_params_pkg holds:
//    - SLEN, STATE_W=1536, STATE_WORDS=24
//    - typedef logic [SLEN-1:0] word_t
//    - typedef word_t state_t [0:23]
//    - FSM enum {INIT,ABSORB,PAD,PERM,SQUEEZE}
//    - PAD_BYTE=8'h40
//  - One sub-module: bash_pad_word (combinational: data, nbytes -> masked/padded word); the rest is flat.
// TESTING
//  Bench uses a stub bash-f (fixed 4-cycle latency) plus a golden model.
//  1. L=128, empty message (s_last, s_nbytes=0)
//     -> one f_start; f_state_o word0=64'h40, words1..15=0, words16..22=0, word23=64'd32.
//  2. Stub returns bash_f_o for input bash_f_i; preload state = bash_f_i via 16 absorbed words
//     -> captured state equals bash_f_o words.
//  3. L=128, exactly 16 full words (last with s_nbytes=8)
//     -> two f_start pulses; second block word0=64'h40, words1..15=0.
//  4. L=256, 3 words, last s_nbytes=3, data 64'h1122334455667788
//     -> word2=64'h0000_0000_4066_7788, words3..7=0, RATE_W=8 respected.
//  5. Backpressure: h_ready held low 10 cycles -> h_valid/h_data stable, s_ready=0; then next message accepted.
//  6. rst_n low during PERM, then release -> outputs 0, stray f_done ignored, clean new hash matches the model.

Source files
------------

// File: rtl/bash_hash_params_pkg.sv
// Shared sizes, word/state types and controller states
// for the bash-hash sponge front end.
package bash_hash_params_pkg;

  localparam int SLEN        = 64;
  localparam int STATE_W     = 1536;
  localparam int STATE_WORDS = 24;

  localparam logic [7:0] PAD_BYTE = 8'h40;

  typedef logic [SLEN-1:0] word_t;
  typedef word_t state_t [0:STATE_WORDS-1];

  typedef enum logic [2:0] {
    INIT,
    ABSORB,
    PAD,
    PERM,
    SQUEEZE
  } fsm_t;

  function automatic int rate_words(input int l);
    return (STATE_W - 4 * l) / SLEN;
  endfunction

endpackage

// File: rtl/bash_pad_word.sv
// Final-word masking: keeps the valid bytes, puts the
// pad marker right after them and clears the rest.
module bash_pad_word
  import bash_hash_params_pkg::*;
(
  input  word_t      data,
  input  logic [3:0] nbytes,
  output word_t      padded
);

  // per byte: keep, mark or clear
  always_comb begin
    padded = '0;
    for (int k = 0; k < 8; k++) begin
      unique case (1'b1)
        (4'(k) < nbytes):
          padded[8*k +: 8] = data[8*k +: 8];
        (4'(k) == nbytes):
          padded[8*k +: 8] = PAD_BYTE;
        default:
          padded[8*k +: 8] = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/bash_sponge_ctrl.sv
// Absorb/squeeze controller around the bash-f core:
// packs and pads message words, runs blocks, shows digest.
module bash_sponge_ctrl
  import bash_hash_params_pkg::*;
#(
  parameter int L = 128
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SLEN-1:0]     s_data,
  input  logic [3:0]          s_nbytes,
  input  logic                s_last,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                f_start,
  output logic [STATE_W-1:0]  f_state_o,
  input  logic [STATE_W-1:0]  f_state_i,
  input  logic                f_done,
  output logic [2*L-1:0]      h_data,
  output logic                h_valid,
  input  logic                h_ready
);

  localparam int RATE_W = rate_words(L);
  localparam int HASH_W = 2 * L;
  localparam int H_WRDS = HASH_W / SLEN;

  localparam logic [4:0] LAST_W   = 5'(RATE_W - 1);
  localparam word_t      CAP_INIT = word_t'(L / 4);

  generate
    if (L != 128 && L != 192 && L != 256) begin : g_bad_l
      $error("bash_sponge_ctrl: L must be 128, 192 or 256");
    end
  endgenerate

  fsm_t       fsm;
  fsm_t       fsm_d;
  state_t     st;
  logic [4:0] wcnt;
  logic       pad_pending;
  logic       final_q;
  logic       last_short;
  word_t      pad_w;

  assign last_short = s_last & (s_nbytes < 4'd8);

  bash_pad_word u_pad (
    .data   (s_data),
    .nbytes (s_nbytes),
    .padded (pad_w)
  );

  // next state and handshake outputs
  always_comb begin
    fsm_d   = fsm;
    s_ready = 1'b0;
    h_valid = 1'b0;
    unique case (fsm)
      INIT: fsm_d = ABSORB;
      ABSORB: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (last_short)
            fsm_d = PERM;
          else if (wcnt == LAST_W)
            fsm_d = PERM;
          else if (s_last)
            fsm_d = PAD;
        end
      end
      PAD: fsm_d = PERM;
      PERM: begin
        if (f_done) begin
          if (final_q)
            fsm_d = SQUEEZE;
          else if (pad_pending)
            fsm_d = PAD;
          else
            fsm_d = ABSORB;
        end
      end
      SQUEEZE: begin
        h_valid = 1'b1;
        if (h_ready)
          fsm_d = INIT;
      end
      default: fsm_d = INIT;
    endcase
  end

  // state register; start pulses on entry to PERM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm     <= INIT;
      f_start <= 1'b0;
    end else begin
      fsm     <= fsm_d;
      f_start <= (fsm_d == PERM) && (fsm != PERM);
    end
  end

  // sponge state, word counter and pad bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STATE_WORDS; i++)
        st[5'(i)] <= '0;
      wcnt        <= '0;
      pad_pending <= 1'b0;
      final_q     <= 1'b0;
    end else begin
      unique case (fsm)
        INIT: begin
          for (int i = 0; i < STATE_WORDS; i++)
            st[5'(i)] <= (i == STATE_WORDS - 1) ? CAP_INIT : '0;
          wcnt        <= '0;
          pad_pending <= 1'b0;
          final_q     <= 1'b0;
        end
        ABSORB: begin
          if (s_valid) begin
            st[wcnt] <= s_last ? pad_w : s_data;
            wcnt     <= wcnt + 5'd1;
            if (last_short) begin
              final_q <= 1'b1;
              for (int i = 0; i < RATE_W; i++)
                if (i > int'(wcnt))
                  st[5'(i)] <= '0;
            end
            if (s_last && !last_short)
              pad_pending <= 1'b1;
          end
        end
        PAD: begin
          st[wcnt] <= word_t'(PAD_BYTE);
          for (int i = 0; i < RATE_W; i++)
            if (i > int'(wcnt))
              st[5'(i)] <= '0;
          pad_pending <= 1'b0;
          final_q     <= 1'b1;
        end
        PERM: begin
          if (f_done) begin
            for (int i = 0; i < STATE_WORDS; i++)
              st[5'(i)] <= f_state_i[SLEN*i +: SLEN];
            wcnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // flatten state toward bash-f and the digest port
  always_comb begin
    f_state_o = '0;
    h_data    = '0;
    for (int i = 0; i < STATE_WORDS; i++)
      f_state_o[SLEN*i +: SLEN] = st[5'(i)];
    for (int i = 0; i < H_WRDS; i++)
      h_data[SLEN*i +: SLEN] = st[5'(i)];
  end

endmodule

// File: tb/tb_bash_sponge_ctrl.sv
// Bench for bash_sponge_ctrl: L=128 and L=256 instances,
// stub bash-f with fixed latency, byte-level sponge model.
module tb_bash_sponge_ctrl;

  localparam int NU = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [63:0]   s_data   [NU];
  logic [3:0]    s_nbytes [NU];
  logic          s_last   [NU];
  logic          s_valid  [NU];
  logic          s_ready  [NU];
  logic          f_start  [NU];
  logic [1535:0] f_so     [NU];
  logic [1535:0] f_si     [NU] = '{default: '0};
  logic          f_done   [NU] = '{default: 1'b0};
  logic          h_valid  [NU];
  logic          h_ready  [NU];
  logic [255:0]  h0;
  logic [511:0]  h1;

  int            cnt  [NU] = '{default: 0};
  logic [1535:0] pend [NU] = '{default: '0};

  int errors = 0;
  int checks = 0;

  logic [1535:0] exp_blk [NU][64];
  logic [511:0]  exp_dig [NU];
  int            wr [NU];
  int            rd [NU];

  logic [7:0]  bytes_q [$];
  logic [63:0] words_q [$];
  logic [3:0]  nb_q    [$];

  always #5 clk = ~clk;

  bash_sponge_ctrl #(.L(128)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data[0]),
    .s_nbytes  (s_nbytes[0]),
    .s_last    (s_last[0]),
    .s_valid   (s_valid[0]),
    .s_ready   (s_ready[0]),
    .f_start   (f_start[0]),
    .f_state_o (f_so[0]),
    .f_state_i (f_si[0]),
    .f_done    (f_done[0]),
    .h_data    (h0),
    .h_valid   (h_valid[0]),
    .h_ready   (h_ready[0])
  );

  bash_sponge_ctrl #(.L(256)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data[1]),
    .s_nbytes  (s_nbytes[1]),
    .s_last    (s_last[1]),
    .s_valid   (s_valid[1]),
    .s_ready   (s_ready[1]),
    .f_start   (f_start[1]),
    .f_state_o (f_so[1]),
    .f_state_i (f_si[1]),
    .f_done    (f_done[1]),
    .h_data    (h1),
    .h_valid   (h_valid[1]),
    .h_ready   (h_ready[1])
  );

  function automatic int lv(input int u);
    return (u == 0) ? 128 : 256;
  endfunction

  function automatic int rb(input int u);
    return (1536 - 4 * lv(u)) / 8;
  endfunction

  // stand-in permutation: any fixed mixing function will do
  function automatic logic [1535:0] bashf(input logic [1535:0] s);
    logic [1535:0] r;
    logic [63:0]   a;
    logic [63:0]   b;
    r = '0;
    for (int i = 0; i < 24; i++) begin
      a = s[64*((i+7)%24) +: 64];
      b = s[64*i +: 64];
      r[64*i +: 64] = {a[50:0], a[63:51]}
                    ^ (b * 64'h9E3779B97F4A7C15)
                    ^ (64'(i+1) * 64'hD6E8FEB86659FD93);
    end
    return r;
  endfunction

  function automatic logic [511:0] hd(input int u);
    return (u == 0) ? {256'b0, h0} : h1;
  endfunction

  // stub bash-f: fixed latency, ignores reset
  always @(posedge clk) begin
    for (int u = 0; u < NU; u++) begin
      f_done[u] <= 1'b0;
      if (f_start[u]) begin
        cnt[u]  <= 4;
        pend[u] <= bashf(f_so[u]);
      end else if (cnt[u] > 0) begin
        cnt[u] <= cnt[u] - 1;
        if (cnt[u] == 1) begin
          f_done[u] <= 1'b1;
          f_si[u]   <= pend[u];
        end
      end
    end
  end

  task automatic chk64(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  task automatic chkw(input string nm,
                      input logic [1535:0] act,
                      input logic [1535:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      for (int i = 0; i < 24; i++) begin
        if (act[64*i +: 64] !== req[64*i +: 64]) begin
          $display("FAIL %s: word %0d got %h, want %h",
                   nm, i, act[64*i +: 64], req[64*i +: 64]);
          break;
        end
      end
    end
  endtask

  task automatic note_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  // per-cycle comparison of both DUTs against the model
  task automatic check_cycle();
    for (int u = 0; u < NU; u++) begin
      if (!rst_n) begin
        rd[u] = wr[u];
        continue;
      end
      if (f_start[u]) begin
        if (rd[u] == wr[u]) begin
          note_fail($sformatf("extra f_start u%0d", u));
        end else begin
          chkw($sformatf("block u%0d #%0d", u, rd[u]),
               f_so[u], exp_blk[u][rd[u] % 64]);
          rd[u]++;
        end
      end
      if (h_valid[u]) begin
        chkw($sformatf("digest u%0d", u),
             {1024'b0, hd(u)}, {1024'b0, exp_dig[u]});
        chk64($sformatf("blocks left u%0d", u),
              64'(wr[u] - rd[u]), 64'd0);
        chk64($sformatf("s_ready squeeze u%0d", u),
              64'(s_ready[u]), 64'd0);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
  endtask

  // sponge model on bytes: pad 0x40 then zeros to a block edge
  task automatic build_model(input int u);
    int            rbn;
    logic [7:0]    p [$];
    logic [1535:0] s;
    rbn = rb(u);
    p   = bytes_q;
    p.push_back(8'h40);
    while (p.size() % rbn != 0)
      p.push_back(8'h00);
    s = '0;
    s[1535:1472] = 64'(lv(u) / 4);
    for (int b = 0; b < p.size() / rbn; b++) begin
      for (int j = 0; j < rbn; j++)
        s[8*j +: 8] = p[b*rbn + j];
      exp_blk[u][wr[u] % 64] = s;
      wr[u]++;
      s = bashf(s);
    end
    exp_dig[u] = s[511:0];
    if (lv(u) == 128)
      exp_dig[u][511:256] = '0;
  endtask

  // split bytes into words; short last word carries junk above
  task automatic prepare(input int u, input bit extra);
    int          n;
    logic [63:0] w;
    n = bytes_q.size();
    words_q.delete();
    nb_q.delete();
    for (int i = 0; i < n / 8; i++) begin
      w = '0;
      for (int k = 0; k < 8; k++)
        w[8*k +: 8] = bytes_q[8*i + k];
      words_q.push_back(w);
      nb_q.push_back(4'd8);
    end
    if ((n % 8) != 0 || n == 0 || extra) begin
      w = {$urandom, $urandom};
      for (int k = 0; k < n % 8; k++)
        w[8*k +: 8] = bytes_q[8*(n/8) + k];
      words_q.push_back(w);
      nb_q.push_back(4'(n % 8));
    end
    build_model(u);
  endtask

  task automatic stream(input int u, input bit gaps, input int maxw);
    int i;
    int budget;
    int lim;
    bit acc;
    i      = 0;
    budget = 0;
    lim    = (maxw < words_q.size()) ? maxw : words_q.size();
    while (i < lim && budget < 3000) begin
      s_valid[u]  = !gaps || ($urandom_range(0, 3) != 0);
      s_data[u]   = words_q[i];
      s_nbytes[u] = nb_q[i];
      s_last[u]   = (i == words_q.size() - 1);
      acc = s_valid[u] && s_ready[u];
      tick();
      budget++;
      if (acc)
        i++;
    end
    s_valid[u] = 1'b0;
    s_last[u]  = 1'b0;
    if (i < lim)
      note_fail($sformatf("stream timeout u%0d", u));
  endtask

  task automatic wait_digest(input int u, input int hold);
    int budget;
    budget = 0;
    while (!h_valid[u] && budget < 400) begin
      tick();
      budget++;
    end
    if (!h_valid[u]) begin
      note_fail($sformatf("digest timeout u%0d", u));
    end else begin
      repeat (hold) tick();
      h_ready[u] = 1'b1;
      tick();
      h_ready[u] = 1'b0;
      chk64($sformatf("h_valid drop u%0d", u),
            64'(h_valid[u]), 64'd0);
    end
  endtask

  task automatic rand_bytes(input int n);
    bytes_q.delete();
    for (int i = 0; i < n; i++)
      bytes_q.push_back(8'($urandom));
  endtask

  initial begin
    int            w0;
    int            u;
    int            n;
    logic [1535:0] lit;
    logic [1535:0] blk;

    for (int k = 0; k < NU; k++) begin
      s_data[k]   = '0;
      s_nbytes[k] = '0;
      s_last[k]   = 1'b0;
      s_valid[k]  = 1'b0;
      h_ready[k]  = 1'b0;
      wr[k]       = 0;
      rd[k]       = 0;
      exp_dig[k]  = '0;
    end

    // reset values
    tick();
    tick();
    for (int k = 0; k < NU; k++) begin
      chk64("reset f_start", 64'(f_start[k]), 64'd0);
      chk64("reset h_valid", 64'(h_valid[k]), 64'd0);
      chk64("reset s_ready", 64'(s_ready[k]), 64'd0);
      chkw("reset f_state_o", f_so[k], '0);
      chkw("reset h_data", {1024'b0, hd(k)}, '0);
    end
    rst_n = 1'b1;
    tick();
    chk64("cap init L128", f_so[0][1535:1472], 64'd32);
    chk64("cap init L256", f_so[1][1535:1472], 64'd64);
    chk64("ready after init", 64'(s_ready[0]), 64'd1);

    // empty message, L=128
    bytes_q.delete();
    w0 = wr[0];
    prepare(0, 1'b0);
    lit = '0;
    lit[7:0] = 8'h40;
    lit[1535:1472] = 64'd32;
    chkw("empty msg model pin", exp_blk[0][w0 % 64], lit);
    chk64("empty msg blocks", 64'(wr[0] - w0), 64'd1);
    stream(0, 1'b0, 1000);
    wait_digest(0, 0);

    // exactly one full block, L=128
    rand_bytes(128);
    w0 = wr[0];
    prepare(0, 1'b0);
    chk64("full block count", 64'(wr[0] - w0), 64'd2);
    blk = exp_blk[0][(w0 + 1) % 64];
    chkw("pad block pin", {512'b0, blk[1023:0]},
         {1472'b0, 64'h40});
    stream(0, 1'b1, 1000);
    wait_digest(0, 1);

    // L=256, three words, last one has 3 valid bytes
    rand_bytes(16);
    bytes_q.push_back(8'h88);
    bytes_q.push_back(8'h77);
    bytes_q.push_back(8'h66);
    w0 = wr[1];
    prepare(1, 1'b0);
    words_q[2] = 64'h1122334455667788;
    blk = exp_blk[1][w0 % 64];
    chk64("L256 word2 pin", blk[191:128], 64'h0000_0000_4066_7788);
    for (int k = 3; k < 8; k++)
      chk64($sformatf("L256 word%0d pin", k), blk[64*k +: 64], 64'd0);
    stream(1, 1'b0, 1000);
    wait_digest(1, 0);

    // digest backpressure, then the next message
    rand_bytes(45);
    prepare(0, 1'b0);
    stream(0, 1'b1, 1000);
    wait_digest(0, 10);
    rand_bytes(23);
    prepare(0, 1'b0);
    stream(0, 1'b0, 1000);
    wait_digest(0, 0);

    // randomised messages on both levels
    for (int it = 0; it < 12; it++) begin
      u = int'($urandom_range(0, 1));
      n = int'($urandom_range(0, 3 * rb(u)));
      if ($urandom_range(0, 2) == 0)
        n = n & ~7;
      rand_bytes(n);
      prepare(u, ($urandom_range(0, 1) == 1));
      stream(u, 1'b1, 1000);
      wait_digest(u, int'($urandom_range(0, 3)));
    end

    // reset while bash-f is busy; late f_done must be ignored
    rand_bytes(160);
    prepare(0, 1'b0);
    stream(0, 1'b0, 16);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk64("mid reset f_start", 64'(f_start[0]), 64'd0);
    chk64("mid reset s_ready", 64'(s_ready[0]), 64'd0);
    chkw("mid reset state", f_so[0], '0);
    tick();
    rst_n = 1'b1;
    rand_bytes(140);
    prepare(0, 1'b0);
    stream(0, 1'b0, 1000);
    wait_digest(0, 0);
    rand_bytes(70);
    prepare(1, 1'b0);
    stream(1, 1'b1, 1000);
    wait_digest(1, 2);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
